codec_access_scheduler: RTL

//  Shares one vertical/horizontal-parity Codec (16-bit data in, 24-bit bit_flip, 16-bit data out) among
//  NUM_REQ requesters via round-robin arbitration. Drives the Codec's data and error-injection inputs.

---
 rtl/codec_access_scheduler.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/codec_access_scheduler.sv
// Round-robin front end sharing one parity Codec among NUM_REQ requesters, with error injection.
// Latency: grant combinational; codec inputs one cycle after handshake; response CODEC_LAT+2 cycles after handshake.
// Backpressure: req_ready is a one-hot grant gated by en; responses have no backpressure.
//
// Ports: clk/rst (sync, active-high); en gates new grants; req_valid/req_data/req_ready per requester;
// flip_mode/flip_idx select injection; codec_data_in/codec_bit_flip drive the Codec, codec_data_out
// returns from it; rsp_* report each completed transaction; issue_cnt/err_cnt are saturating statistics.
module codec_access_scheduler #(
    parameter int NUM_REQ   = 4,
    parameter int CODEC_LAT = 1,
    parameter int CNT_W     = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [16*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [1:0]              flip_mode,
    input  logic [4:0]              flip_idx,
    output logic [15:0]             codec_data_in,
    output logic [23:0]             codec_bit_flip,
    input  logic [15:0]             codec_data_out,
    output logic                    rsp_valid,
    output logic [2:0]              rsp_id,
    output logic [15:0]             rsp_data,
    output logic                    rsp_injected,
    output logic                    rsp_mismatch,
    output logic [CNT_W-1:0]        issue_cnt,
    output logic [CNT_W-1:0]        err_cnt
);

    typedef struct packed {
        logic        vld;
        logic [2:0]  id;
        logic [15:0] dat;
        logic        inj;
    } tag_t;

    logic [2:0]       ptr_q, ptr_d;
    logic [4:0]       sweep_q, sweep_d;
    logic [7:0]       lfsr_q, lfsr_d;
    logic [15:0]      codec_data_in_q, codec_data_in_d;
    logic [23:0]      codec_bit_flip_q, codec_bit_flip_d;
    tag_t             tag_q [CODEC_LAT+1];
    tag_t             tag_d [CODEC_LAT+1];
    logic             rsp_valid_q, rsp_valid_d;
    logic [2:0]       rsp_id_q, rsp_id_d;
    logic [15:0]      rsp_data_q, rsp_data_d;
    logic             rsp_injected_q, rsp_injected_d;
    logic             rsp_mismatch_q, rsp_mismatch_d;
    logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic [NUM_REQ-1:0] grant;
    logic [2:0]         grant_id;
    logic               hs;
    logic [15:0]        sel_data;
    logic [23:0]        flip_sel;
    logic [4:0]         lfsr_idx;
    logic               lfsr_fb;
    logic               err_inc;
    tag_t               cap;
    int                 slot;

    // Scan from the farthest slot back to the pointer so the nearest asserted
    // request (first at/after the pointer, wrapping) is the last one written.
    always_comb begin
        grant_id = '0;
        slot     = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            slot = (int'(ptr_q) + k) % NUM_REQ;
            if (req_valid[slot]) begin
                grant_id = 3'(slot);
            end
        end
        grant = '0;
        if (en && !rst && (|req_valid)) begin
            grant = NUM_REQ'(1) << grant_id;
        end
    end

    assign req_ready = grant;
    assign hs        = |grant;
    assign sel_data  = req_data[16*grant_id +: 16];
    assign lfsr_idx  = 5'(lfsr_q % 8'd24);
    assign lfsr_fb   = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

    always_comb begin
        flip_sel = '0;
        case (flip_mode)
            2'b01:   flip_sel = (flip_idx < 5'd24) ? (24'd1 << flip_idx) : '0;
            2'b10:   flip_sel = 24'd1 << sweep_q;
            2'b11:   flip_sel = 24'd1 << lfsr_idx;
            default: flip_sel = '0;
        endcase
    end

    always_comb begin
        ptr_d            = ptr_q;
        sweep_d          = sweep_q;
        lfsr_d           = lfsr_q;
        codec_data_in_d  = codec_data_in_q;
        codec_bit_flip_d = '0;
        if (hs) begin
            ptr_d            = (int'(grant_id) == NUM_REQ - 1) ? 3'd0 : grant_id + 3'd1;
            codec_data_in_d  = sel_data;
            codec_bit_flip_d = flip_sel;
            // Injection state only advances when its own mode is the one issuing.
            if (flip_mode == 2'b10) begin
                sweep_d = (sweep_q == 5'd23) ? 5'd0 : sweep_q + 5'd1;
            end
            if (flip_mode == 2'b11) begin
                lfsr_d = {lfsr_q[6:0], lfsr_fb};
            end
        end
    end

    // Tag stage k is valid in cycle t+1+k; the last stage lines up with
    // codec_data_out for the transaction it describes.
    always_comb begin
        tag_d[0].vld = hs;
        tag_d[0].id  = grant_id;
        tag_d[0].dat = sel_data;
        tag_d[0].inj = |flip_sel;
        for (int k = 1; k <= CODEC_LAT; k++) begin
            tag_d[k] = tag_q[k-1];
        end
    end

    assign cap     = tag_q[CODEC_LAT];
    assign err_inc = cap.vld && (codec_data_out != cap.dat);

    always_comb begin
        rsp_valid_d    = cap.vld;
        rsp_id_d       = rsp_id_q;
        rsp_data_d     = rsp_data_q;
        rsp_injected_d = rsp_injected_q;
        rsp_mismatch_d = rsp_mismatch_q;
        if (cap.vld) begin
            rsp_id_d       = cap.id;
            rsp_data_d     = codec_data_out;
            rsp_injected_d = cap.inj;
            rsp_mismatch_d = err_inc;
        end
        issue_cnt_d = (hs && !(&issue_cnt_q)) ? issue_cnt_q + 1'b1 : issue_cnt_q;
        err_cnt_d   = (err_inc && !(&err_cnt_q)) ? err_cnt_q + 1'b1 : err_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q            <= '0;
            sweep_q          <= '0;
            lfsr_q           <= 8'h01;
            codec_data_in_q  <= '0;
            codec_bit_flip_q <= '0;
            for (int k = 0; k <= CODEC_LAT; k++) begin
                tag_q[k] <= '0;
            end
            rsp_valid_q      <= 1'b0;
            rsp_id_q         <= '0;
            rsp_data_q       <= '0;
            rsp_injected_q   <= 1'b0;
            rsp_mismatch_q   <= 1'b0;
            issue_cnt_q      <= '0;
            err_cnt_q        <= '0;
        end else begin
            ptr_q            <= ptr_d;
            sweep_q          <= sweep_d;
            lfsr_q           <= lfsr_d;
            codec_data_in_q  <= codec_data_in_d;
            codec_bit_flip_q <= codec_bit_flip_d;
            for (int k = 0; k <= CODEC_LAT; k++) begin
                tag_q[k] <= tag_d[k];
            end
            rsp_valid_q      <= rsp_valid_d;
            rsp_id_q         <= rsp_id_d;
            rsp_data_q       <= rsp_data_d;
            rsp_injected_q   <= rsp_injected_d;
            rsp_mismatch_q   <= rsp_mismatch_d;
            issue_cnt_q      <= issue_cnt_d;
            err_cnt_q        <= err_cnt_d;
        end
    end

    assign codec_data_in  = codec_data_in_q;
    assign codec_bit_flip = codec_bit_flip_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_id         = rsp_id_q;
    assign rsp_data       = rsp_data_q;
    assign rsp_injected   = rsp_injected_q;
    assign rsp_mismatch   = rsp_mismatch_q;
    assign issue_cnt      = issue_cnt_q;
    assign err_cnt        = err_cnt_q;

endmodule
